// File: rtl/sound_arbiter_if.sv
// Request/grant and synthesizer-control bundle for sound_arbiter.
// slave = arbiter side, master = requesters + synthesizer side.
interface sound_arbiter_if #(
  parameter int OCT_W  = 2,
  parameter int NOTE_W = 3,
  parameter int LEN_W  = 3
);
  logic                  en;
  logic [2:0]            req;
  logic [3*OCT_W-1:0]    req_oct;
  logic [3*NOTE_W-1:0]   req_note;
  logic [3*LEN_W-1:0]    req_len;
  logic [2:0]            gnt;
  logic [2:0]            done;
  logic [2:0]            drop;
  logic                  snd_start;
  logic                  snd_abort;
  logic [OCT_W-1:0]      snd_oct;
  logic [NOTE_W-1:0]     snd_note;
  logic [LEN_W-1:0]      snd_len;
  logic                  snd_over;
  logic                  busy;

  modport slave (
    input  en, req, req_oct, req_note, req_len, snd_over,
    output gnt, done, drop, snd_start, snd_abort, snd_oct, snd_note, snd_len, busy
  );

  modport master (
    output en, req, req_oct, req_note, req_len, snd_over,
    input  gnt, done, drop, snd_start, snd_abort, snd_oct, snd_note, snd_len, busy
  );
endinterface

// File: rtl/sound_arbiter.sv
// Shares one note synthesizer among live hit (0), record playback (1) and
// song autoplay (2). Fixed priority, silent gap after every note, and a
// live hit may cut short a lower-priority note. All outputs are flops.
module sound_arbiter #(
  parameter int OCT_W      = 2,
  parameter int NOTE_W     = 3,
  parameter int LEN_W      = 3,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 2**24
) (
  input  logic           clk,
  input  logic           rst,
  sound_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

  state_t              state, state_n;
  logic [2:0]          gnt, gnt_n, done, done_n, drop, drop_n;
  logic                start, start_n, abort, abort_n, busy;
  logic [OCT_W-1:0]    oct, oct_n;
  logic [NOTE_W-1:0]   note, note_n;
  logic [LEN_W-1:0]    len, len_n;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [GW-1:0]       gcnt, gcnt_n;
  logic                req0_q;
  logic [1:0]          win;

  // Fixed priority: lowest index wins.
  assign win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);

  assign bus.gnt       = gnt;
  assign bus.done      = done;
  assign bus.drop      = drop;
  assign bus.snd_start = start;
  assign bus.snd_abort = abort;
  assign bus.snd_oct   = oct;
  assign bus.snd_note  = note;
  assign bus.snd_len   = len;
  assign bus.busy      = busy;

  // Next state plus next value of every registered output.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    drop_n  = '0;
    start_n = 1'b0;
    abort_n = 1'b0;
    oct_n   = oct;
    note_n  = note;
    len_n   = len;
    tcnt_n  = tcnt;
    gcnt_n  = gcnt;
    if (!bus.en) begin
      // Disable kills any note in flight; the owner learns via drop.
      state_n = IDLE;
      gnt_n   = '0;
      tcnt_n  = '0;
      gcnt_n  = '0;
      if (state == START || state == PLAY) begin
        abort_n = 1'b1;
        drop_n  = gnt;
      end
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          gnt_n   = 3'(3'b001 << win);
          oct_n   = bus.req_oct[win*OCT_W +: OCT_W];
          note_n  = bus.req_note[win*NOTE_W +: NOTE_W];
          len_n   = bus.req_len[win*LEN_W +: LEN_W];
          state_n = START;
        end
        START: begin
          start_n = 1'b1;
          tcnt_n  = '0;
          state_n = PLAY;
        end
        PLAY: begin
          // Normal completion beats a simultaneous preemption.
          if (bus.snd_over) begin
            done_n  = gnt;
            state_n = GAP;
          end else if (bus.req[0] && !req0_q && !gnt[0]) begin
            abort_n = 1'b1;
            drop_n  = gnt;
            state_n = GAP;
          end else if (tcnt == T_LAST) begin
            abort_n = 1'b1;
            drop_n  = gnt;
            state_n = GAP;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
          if (state_n == GAP) begin
            gnt_n  = '0;
            tcnt_n = '0;
            gcnt_n = '0;
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            gcnt_n  = '0;
            state_n = IDLE;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers; req0_q feeds live-hit rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      drop   <= '0;
      start  <= 1'b0;
      abort  <= 1'b0;
      oct    <= '0;
      note   <= '0;
      len    <= '0;
      tcnt   <= '0;
      gcnt   <= '0;
      busy   <= 1'b0;
      req0_q <= 1'b0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      done   <= done_n;
      drop   <= drop_n;
      start  <= start_n;
      abort  <= abort_n;
      oct    <= oct_n;
      note   <= note_n;
      len    <= len_n;
      tcnt   <= tcnt_n;
      gcnt   <= gcnt_n;
      busy   <= (state_n != IDLE);
      req0_q <= bus.req[0];
    end
  end
endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter (TIMEOUT shortened to 64).
module tb_sound_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sound_arbiter_if #(.OCT_W(2), .NOTE_W(3), .LEN_W(3)) bus ();

  sound_arbiter #(.TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [1:0] o, input logic [2:0] n, input logic [2:0] l);
    bus.req_oct[i*2 +: 2]  = o;
    bus.req_note[i*3 +: 3] = n;
    bus.req_len[i*3 +: 3]  = l;
  endtask

  task automatic wait_gnt(input string tag);
    for (int k = 0; k < 40 && bus.gnt == 3'b000; k++) step();
    chk({tag, "_gnt_seen"}, (bus.gnt != 3'b000), 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && bus.busy; k++) step();
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  // Wait for grant, check owner/note, then finish the note normally.
  task automatic play_note(input string tag, input logic [2:0] g, input logic [2:0] n);
    wait_gnt(tag);
    chk({tag, "_gnt"}, bus.gnt, g);
    chk({tag, "_note"}, bus.snd_note, n);
    step();
    chk({tag, "_start"}, bus.snd_start, 1);
    repeat (5) step();
    bus.snd_over = 1'b1;
    step();
    bus.snd_over = 1'b0;
    chk({tag, "_done"}, bus.done, g);
    chk({tag, "_nodrop"}, bus.drop, 0);
  endtask

  // Continuous invariants: one owner at most, done/drop never together.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", ($countones(bus.gnt) <= 1), 1);
      chk("done_drop_excl", (|bus.done && |bus.drop), 0);
    end
  end

  initial begin
    int k;
    bus.en = 1'b1; bus.req = '0; bus.snd_over = 1'b0;
    bus.req_oct = '0; bus.req_note = '0; bus.req_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_note", bus.snd_note, 0);
    chk("rst_start", bus.snd_start, 0);
    chk("rst_abort", bus.snd_abort, 0);
    rst = 1'b0;
    step();

    // Single song note with latency and gap timing
    set_src(2, 2'd1, 3'd5, 3'd2);
    bus.req = 3'b100;
    step();
    chk("t1_gnt", bus.gnt, 3'b100);
    chk("t1_note", bus.snd_note, 5);
    chk("t1_oct", bus.snd_oct, 1);
    chk("t1_len", bus.snd_len, 2);
    chk("t1_start_early", bus.snd_start, 0);
    step();
    chk("t1_start", bus.snd_start, 1);
    repeat (49) step();
    bus.snd_over = 1'b1;
    step();
    bus.snd_over = 1'b0;
    chk("t1_done", bus.done, 3'b100);
    chk("t1_gnt_off", bus.gnt, 0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.snd_start) begin k = i; break; end
    end
    chk("t1_restart_dist", k, 18);
    repeat (3) step();
    bus.snd_over = 1'b1;
    step();
    bus.snd_over = 1'b0;
    bus.req = 3'b000;
    chk("t1_done2", bus.done, 3'b100);
    wait_idle("t1");

    // All three requesting: served 0, 1, 2
    set_src(0, 2'd0, 3'd1, 3'd1);
    set_src(1, 2'd2, 3'd2, 3'd1);
    set_src(2, 2'd3, 3'd3, 3'd1);
    bus.req = 3'b111;
    play_note("t2a", 3'b001, 3'd1);
    bus.req = 3'b110;
    play_note("t2b", 3'b010, 3'd2);
    bus.req = 3'b100;
    play_note("t2c", 3'b100, 3'd3);
    bus.req = 3'b000;
    wait_idle("t2");

    // Live hit preempts song note 10 cycles into PLAY
    set_src(2, 2'd1, 3'd6, 3'd3);
    set_src(0, 2'd2, 3'd4, 3'd1);
    bus.req = 3'b100;
    wait_gnt("t3");
    step();
    chk("t3_start", bus.snd_start, 1);
    repeat (10) step();
    bus.req = 3'b101;
    step();
    chk("t3_abort", bus.snd_abort, 1);
    chk("t3_drop", bus.drop, 3'b100);
    chk("t3_nodone", bus.done, 0);
    bus.req = 3'b001;
    play_note("t3b", 3'b001, 3'd4);
    bus.req = 3'b000;
    wait_idle("t3");

    // snd_over and req[0] rise in the same cycle: completion wins
    bus.req = 3'b100;
    wait_gnt("t4");
    step();
    repeat (3) step();
    bus.snd_over = 1'b1;
    bus.req = 3'b101;
    step();
    bus.snd_over = 1'b0;
    chk("t4_done", bus.done, 3'b100);
    chk("t4_drop", bus.drop, 0);
    chk("t4_abort", bus.snd_abort, 0);
    bus.req = 3'b001;
    play_note("t4b", 3'b001, 3'd4);
    bus.req = 3'b000;
    wait_idle("t4");

    // Timeout: abort exactly 64 cycles after snd_start
    set_src(1, 2'd0, 3'd7, 3'd7);
    bus.req = 3'b010;
    wait_gnt("t5");
    chk("t5_note", bus.snd_note, 7);
    step();
    chk("t5_start", bus.snd_start, 1);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.snd_abort) begin k = i; break; end
    end
    chk("t5_abort_dist", k, 64);
    chk("t5_drop", bus.drop, 3'b010);
    bus.req = 3'b000;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!bus.busy) begin k = i; break; end
    end
    chk("t5_gap_len", k, 16);

    // en dropped mid-PLAY
    bus.req = 3'b001;
    wait_gnt("t6");
    step();
    repeat (3) step();
    bus.en = 1'b0;
    step();
    chk("t6_abort", bus.snd_abort, 1);
    chk("t6_drop", bus.drop, 3'b001);
    chk("t6_busy", bus.busy, 0);
    chk("t6_gnt", bus.gnt, 0);
    step();
    chk("t6_abort_pulse", bus.snd_abort, 0);
    chk("t6_ignored", bus.gnt, 0);
    bus.req = 3'b000;
    bus.en = 1'b1;
    step();

    // Asynchronous reset mid-PLAY
    bus.req = 3'b100;
    wait_gnt("t7");
    step();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t7_gnt", bus.gnt, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_note", bus.snd_note, 0);
    chk("t7_abort", bus.snd_abort, 0);
    bus.req = 3'b000;
    step();
    rst = 1'b0;
    step();
    chk("t7_abort_after", bus.snd_abort, 0);
    chk("t7_drop_after", bus.drop, 0);

    // snd_over while idle is ignored
    bus.snd_over = 1'b1;
    step();
    bus.snd_over = 1'b0;
    chk("t8_done", bus.done, 0);
    chk("t8_gnt", bus.gnt, 0);
    chk("t8_busy", bus.busy, 0);
    chk("t8_start", bus.snd_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
